// File: rtl/dmem_pkg.sv
// Shared access-size encoding and byte-lane helpers for the data memory.
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_t;

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SIZE_BYTE: be = 4'b0001 << lane;
            SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {lane, 3'b000});
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: r = is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
            SIZE_HALF: r = is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
            default:   r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Store-side lane alignment: replicates store data across lanes and builds the byte-enable mask.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] wdata_rep_o,
    output logic [3:0]  be_o
);

    always_comb begin
        wdata_rep_o = wdata_i;
        case (size_i)
            SIZE_BYTE: wdata_rep_o = {4{wdata_i[7:0]}};
            SIZE_HALF: wdata_rep_o = {2{wdata_i[15:0]}};
            default:   wdata_rep_o = wdata_i;
        endcase
    end

    assign be_o = byte_enable(size_i, lane_i);

endmodule

// File: rtl/data_memory_sized.sv
// Sized-access data memory (byte/half/word) with registered loads and error flags.
// Build option: DMEM_BYPASS_EN forwards the merged word to a simultaneous load of the same word.
module data_memory_sized
    import dmem_pkg::*;
#(
    parameter int    ADDR_WIDTH = 32,
    parameter int    DEPTH      = 32,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  memread,
    input  logic                  memwrite,
    input  logic [1:0]            size,
    input  logic                  load_unsigned,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  read_valid,
    output logic                  misaligned,
    output logic                  out_of_range
);

    localparam int IDX_W = $clog2(DEPTH);

    function automatic logic [DEPTH-1:0][31:0] init_image();
        logic [DEPTH-1:0][31:0]  packed_img;
        for (int i = 0; i < DEPTH; i++) packed_img[i] = 32'd0;
        if (INIT_FILE == "") begin
            packed_img[0] = 32'd100;
            packed_img[1] = 32'd1000;
            packed_img[2] = 32'd500;
        end
        return packed_img;
    endfunction

    // Array is deliberately outside the reset domain so contents survive reset.
    logic [DEPTH-1:0][31:0] mem_q = init_image();

    logic [31:0] readdata_q, readdata_d;
    logic        read_valid_q, read_valid_d;
    logic        misaligned_q, misaligned_d;
    logic        out_of_range_q, out_of_range_d;
    logic        armed_q;

    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             oor, mis, err, store_ok;
    logic [31:0]      old_word, merged, src_word, wdata_rep;
    logic [3:0]       be;

    dmem_lane_align u_align (
        .size_i      (size),
        .lane_i      (lane),
        .wdata_i     (writedata),
        .wdata_rep_o (wdata_rep),
        .be_o        (be)
    );

    assign idx      = address[IDX_W+1:2];
    assign lane     = address[1:0];
    assign oor      = address[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(DEPTH);
    assign err      = oor | mis;
    assign old_word = mem_q[idx];
    assign store_ok = memwrite & armed_q & ~err;

    always_comb begin
        mis = 1'b0;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = lane[0];
            SIZE_WORD: mis = (lane != 2'b00);
            default:   mis = 1'b1;
        endcase
    end

    always_comb begin
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) merged[8*k +: 8] = wdata_rep[8*k +: 8];
        end
    end

`ifdef DMEM_BYPASS_EN
    assign src_word = store_ok ? merged : old_word;
`else
    assign src_word = old_word;
`endif

    always_comb begin
        readdata_d     = readdata_q;
        read_valid_d   = memread;
        misaligned_d   = (memread | memwrite) & mis & ~oor;
        out_of_range_d = (memread | memwrite) & oor;
        if (memread) begin
            readdata_d = err ? 32'd0 : load_extract(src_word, size, lane, load_unsigned);
        end
    end

    // armed_q stays low for the first edge after reset release, dropping a store that lands there.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q     <= 32'd0;
            read_valid_q   <= 1'b0;
            misaligned_q   <= 1'b0;
            out_of_range_q <= 1'b0;
            armed_q        <= 1'b0;
        end else begin
            readdata_q     <= readdata_d;
            read_valid_q   <= read_valid_d;
            misaligned_q   <= misaligned_d;
            out_of_range_q <= out_of_range_d;
            armed_q        <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (store_ok) mem_q[idx] <= merged;
    end

    assign readdata     = readdata_q;
    assign read_valid   = read_valid_q;
    assign misaligned   = misaligned_q;
    assign out_of_range = out_of_range_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Self-checking bench for data_memory_sized against a byte-addressed reference model.
module tb_data_memory_sized;

    localparam int DEPTH = 32;
    localparam int AW    = 32;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        memread, memwrite, load_unsigned;
    logic [1:0]  size;
    logic [AW-1:0] address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        read_valid, misaligned, out_of_range;

    data_memory_sized #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .INIT_FILE("")) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .memread       (memread),
        .memwrite      (memwrite),
        .size          (size),
        .load_unsigned (load_unsigned),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .read_valid    (read_valid),
        .misaligned    (misaligned),
        .out_of_range  (out_of_range)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  mb [DEPTH*4];
    logic [31:0] exp_rdata;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        case (sz)
            2'b00:   v = uns ? {24'b0, mb[a]} : {{24{mb[a][7]}}, mb[a]};
            2'b01:   v = uns ? {16'b0, mb[a+1], mb[a]} : {{16{mb[a+1][7]}}, mb[a+1], mb[a]};
            default: v = {mb[a+3], mb[a+2], mb[a+1], mb[a]};
        endcase
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int nbytes;
        nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int i = 0; i < nbytes; i++) mb[a+i] = 8'(wd >> (8*i));
    endtask

    task automatic access(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd);
        logic oor_e, mis_e, err;
        logic [31:0] pre;
        @(negedge clock);
        memread = rd; memwrite = wr; size = sz; load_unsigned = uns; address = a; writedata = wd;
        oor_e = (a >> 2) >= DEPTH;
        mis_e = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        err   = oor_e || mis_e;
        pre   = err ? 32'd0 : model_load(a, sz, uns);
        if (wr && !err) model_store(a, sz, wd);
        if (rd) begin
`ifdef DMEM_BYPASS_EN
            exp_rdata = err ? 32'd0 : model_load(a, sz, uns);
`else
            exp_rdata = pre;
`endif
        end
        @(posedge clock); #1;
        memread = 1'b0; memwrite = 1'b0;
        check_eq({tag, ".rdata"}, readdata, exp_rdata);
        check_eq({tag, ".valid"}, {31'b0, read_valid}, {31'b0, rd});
        check_eq({tag, ".mis"}, {31'b0, misaligned}, {31'b0, (rd | wr) & mis_e & ~oor_e});
        check_eq({tag, ".oor"}, {31'b0, out_of_range}, {31'b0, (rd | wr) & oor_e});
    endtask

    task automatic reread_all(input string tag);
        for (int w = 0; w < DEPTH; w++) access(tag, 1'b1, 1'b0, 2'b10, 1'b0, 32'(w*4), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".rdata"}, readdata, 32'd0);
        check_eq({tag, ".valid"}, {31'b0, read_valid}, 32'd0);
        check_eq({tag, ".mis"}, {31'b0, misaligned}, 32'd0);
        check_eq({tag, ".oor"}, {31'b0, out_of_range}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'h00;
        model_store(32'h0, 2'b10, 32'd100);
        model_store(32'h4, 2'b10, 32'd1000);
        model_store(32'h8, 2'b10, 32'd500);
        exp_rdata = 32'd0;

        memread = 0; memwrite = 0; size = 2'b10; load_unsigned = 0; address = '0; writedata = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 check_reset_outputs("reset");

        // Store pending exactly as reset releases: must be dropped.
        @(negedge clock);
        memwrite = 1'b1; address = 32'h0; writedata = 32'hDEADBEEF; size = 2'b10;
        reset_n = 1'b1;
        @(posedge clock); #1;
        memwrite = 1'b0;
        check_eq("release.valid", {31'b0, read_valid}, 32'd0);

        access("lw0", 1, 0, 2'b10, 0, 32'h0, 0);
        access("lw4", 1, 0, 2'b10, 0, 32'h4, 0);
        access("lw8", 1, 0, 2'b10, 0, 32'h8, 0);
        check_eq("preload.w1", exp_rdata, 32'd500);

        access("sw10", 0, 1, 2'b10, 0, 32'h10, 32'h12345678);
        access("sb11", 0, 1, 2'b00, 0, 32'h11, 32'h000000AB);
        access("lw10", 1, 0, 2'b10, 0, 32'h10, 0);
        check_eq("merge.sb", exp_rdata, 32'h1234AB78);
        access("lb11", 1, 0, 2'b00, 0, 32'h11, 0);
        access("lbu11", 1, 0, 2'b00, 1, 32'h11, 0);

        access("sh16", 0, 1, 2'b01, 0, 32'h16, 32'h00008001);
        access("lh16", 1, 0, 2'b01, 0, 32'h16, 0);
        access("lhu16", 1, 0, 2'b01, 1, 32'h16, 0);
        access("lw14", 1, 0, 2'b10, 0, 32'h14, 0);

        access("lw6", 1, 0, 2'b10, 0, 32'h6, 0);
        access("sw_oor", 0, 1, 2'b10, 0, 32'(DEPTH*4), 32'hFFFFFFFF);
        access("lw_oor", 1, 0, 2'b10, 0, 32'(DEPTH*4 + 8), 0);
        access("rsv", 1, 0, 2'b11, 0, 32'h0, 0);
        reread_all("scan1");

        access("sw20", 0, 1, 2'b10, 0, 32'h20, 32'd5);
        access("rw20", 1, 1, 2'b10, 0, 32'h20, 32'd9);
        access("lw20", 1, 0, 2'b10, 0, 32'h20, 0);
        access("sw24", 0, 1, 2'b10, 0, 32'h24, 32'hCAFEF00D);
        access("lw24", 1, 0, 2'b10, 0, 32'h24, 0);

        for (int n = 0; n < 400; n++) begin
            logic rd, wr;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            access("rnd", rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, DEPTH*4 + 15)), $urandom);
        end

        // Async reset between edges while a load is pending.
        access("pre_rst", 1, 0, 2'b10, 0, 32'h4, 0);
        @(negedge clock);
        memread = 1'b1; address = 32'h4; size = 2'b10;
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        exp_rdata = 32'd0;
        @(posedge clock); #1;
        memread = 1'b0;
        check_reset_outputs("rst_hold");
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        reread_all("scan2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
